fp_accum: RTL and testbench

- Downstream consumer of the combinational Q5.3 unsigned fixed-point multiplier.
- Accumulates frames of LEN Q5.3 products into a wide accumulator.
- Per frame it presents:
  - the raw sum;
  - a rounded mean, saturated back to Q5.3;
  - a sticky overflow flag.
- Uses valid/ready handshakes on input and output, so the multiplier output can be streamed into it one product per cycle.

---
 rtl/fp_accum.sv | 111 +++++++++++
 tb/tb_fp_accum.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fp_accum.sv
// Frame accumulator for Q5.3 products: sum, rounded mean, sticky overflow.
// Ports: clk, rst_n, in_valid/in_ready/in_data, out_valid/out_ready/out_sum/out_mean/out_ovf.
module fp_accum #(
  parameter int LEN      = 4,
  parameter int LOG2_LEN = 2,
  parameter int ACC_W    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_mean,
  output logic             out_ovf
);

  generate
    if ((1 << LOG2_LEN) != LEN || LEN < 2 || LEN > 256 || ACC_W < 9) begin : g_bad
      $error("fp_accum: bad LEN/LOG2_LEN/ACC_W");
    end
  endgenerate

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [LOG2_LEN-1:0]  r_count;
  logic [ACC_W-1:0]     r_acc;
  logic                 r_ovf;
  logic [ACC_W-1:0]     r_sum;
  logic [7:0]           r_mean;
  logic                 r_out_ovf;

  logic                 w_xfer;
  logic                 w_last;
  logic                 w_hs;
  logic [ACC_W:0]       w_sum;
  logic                 w_sat;
  logic [ACC_W-1:0]     w_acc_nx;
  logic                 w_ovf_nx;
  logic [ACC_W:0]       w_rnd;
  logic [ACC_W:0]       w_shift;
  logic [7:0]           w_mean;

  assign w_xfer   = in_valid && in_ready;
  assign w_last   = w_xfer && (r_count == LOG2_LEN'(LEN - 1));
  assign w_hs     = out_valid && out_ready;
  assign w_sum    = {1'b0, r_acc} + (ACC_W+1)'(in_data);
  assign w_sat    = w_sum[ACC_W];
  assign w_acc_nx = w_sat ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  assign w_ovf_nx = r_ovf | w_sat;

  // Round half up, then clamp the quotient back into Q5.3.
  assign w_rnd    = {1'b0, w_acc_nx} + (ACC_W+1)'(LEN / 2);
  assign w_shift  = w_rnd >> LOG2_LEN;
  assign w_mean   = (|w_shift[ACC_W:8]) ? 8'hFF : w_shift[7:0];

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    unique case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (w_last) w_next = HOLD;
      end
      HOLD: begin
        if (w_hs) w_next = ACCUM;
      end
      default: w_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ACCUM;
      r_count   <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_mean    <= '0;
      r_out_ovf <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_acc   <= w_acc_nx;
        r_ovf   <= w_ovf_nx;
        r_count <= r_count + 1'b1;
      end
      if (w_last) begin
        r_sum     <= w_acc_nx;
        r_mean    <= w_mean;
        r_out_ovf <= w_ovf_nx;
      end
      if (w_hs) begin
        r_acc   <= '0;
        r_ovf   <= 1'b0;
        r_count <= '0;
      end
    end
  end

  // HOLD is entered only from a registered frame completion.
  assign out_valid = (r_state == HOLD);
  assign out_sum   = r_sum;
  assign out_mean  = r_mean;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_fp_accum.sv
// Directed bench for fp_accum: LEN=4 instance plus a LEN=32 overflow instance.
// Expected values are hand-computed constants.
module tb_fp_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_sum;
  logic [7:0]  out_mean;
  logic        out_ovf;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_in_data = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [11:0] b_out_sum;
  logic [7:0]  b_out_mean;
  logic        b_out_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_accum #(.LEN(4), .LOG2_LEN(2), .ACC_W(12)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_mean(out_mean), .out_ovf(out_ovf)
  );

  fp_accum #(.LEN(32), .LOG2_LEN(5), .ACC_W(12)) u_big (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_mean(b_out_mean), .out_ovf(b_out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    check("push_rdy", {31'd0, in_ready}, 1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_big(input logic [7:0] d);
    b_in_valid = 1'b1;
    b_in_data  = d;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    check("wait_valid", {31'd0, out_valid}, 1);
  endtask

  task automatic res(input string tag, input int s, input int m, input int o);
    check({tag, "_valid"}, {31'd0, out_valid}, 1);
    check({tag, "_sum"}, {20'd0, out_sum}, s);
    check({tag, "_mean"}, {24'd0, out_mean}, m);
    check({tag, "_ovf"}, {31'd0, out_ovf}, o);
  endtask

  initial begin
    tick();
    tick();
    check("rst_rdy", {31'd0, in_ready}, 1);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_sum", {20'd0, out_sum}, 0);
    check("rst_mean", {24'd0, out_mean}, 0);
    check("rst_ovf", {31'd0, out_ovf}, 0);
    rst_n = 1'b1;
    tick();

    // back-to-back 15 x4
    for (int i = 0; i < 4; i++) push(8'd15);
    res("t1", 60, 15, 0);
    check("t1_busy", {31'd0, in_ready}, 0);
    tick();
    check("t1_drop", {31'd0, out_valid}, 0);
    check("t1_rdy", {31'd0, in_ready}, 1);

    push(8'd10); push(8'd11); push(8'd0); push(8'd0);
    res("t2a", 21, 5, 0);
    tick();
    for (int i = 0; i < 4; i++) push(8'd255);
    res("t2b", 1020, 255, 0);
    tick();

    // backpressure with junk on the input
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'd8);
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_rdy", {31'd0, in_ready}, 0);
      res("bp", 32, 8, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_drop", {31'd0, out_valid}, 0);
    for (int i = 0; i < 4; i++) push(8'd1);
    res("bp_next", 4, 1, 0);
    tick();

    // gapped input
    in_data = 8'd16;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      tick();
    end
    in_valid = 1'b0;
    wait_valid(4);
    res("gap", 64, 16, 0);
    tick();

    // overflow on the LEN=32 instance
    for (int i = 0; i < 32; i++) push_big(8'd255);
    check("big_valid", {31'd0, b_out_valid}, 1);
    check("big_sum", {20'd0, b_out_sum}, 4095);
    check("big_mean", {24'd0, b_out_mean}, 128);
    check("big_ovf", {31'd0, b_out_ovf}, 1);
    tick();
    for (int i = 0; i < 32; i++) push_big(8'd1);
    check("big2_valid", {31'd0, b_out_valid}, 1);
    check("big2_sum", {20'd0, b_out_sum}, 32);
    check("big2_mean", {24'd0, b_out_mean}, 1);
    check("big2_ovf", {31'd0, b_out_ovf}, 0);
    tick();

    // reset mid-frame
    push(8'd50); push(8'd50);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_rdy", {31'd0, in_ready}, 1);
    check("mrst_valid", {31'd0, out_valid}, 0);
    check("mrst_sum", {20'd0, out_sum}, 0);
    for (int i = 0; i < 4; i++) push(8'd8);
    res("mrst", 32, 8, 0);
    tick();

    // reset while holding a result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'd8);
    res("hrst_pre", 32, 8, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("hrst_valid", {31'd0, out_valid}, 0);
    check("hrst_sum", {20'd0, out_sum}, 0);
    check("hrst_mean", {24'd0, out_mean}, 0);
    check("hrst_rdy", {31'd0, in_ready}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
